tile_seq_controller: RTL and testbench

Parametrised successor to the single-tile accelerator controller. It sequences a full tiled matrix multiply on the systolic array: weight preload, ifmap streaming, pipeline drain and output handshake. It walks cfg_n_tiles output tiles × cfg_k_tiles reduction tiles. Weight loads are double-buffered: the next tile's weights load into the shadow bank while the current tile streams. Optional accumulation across K tiles is supported, and it sits between top-level control and the datapath buffers.

---
 rtl/tile_seq_controller_if.sv | 33 +++
 rtl/tile_seq_controller.sv | 217 +++++++++++++++++++++
 tb/tb_tile_seq_controller.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_seq_controller_if.sv
// Handshake and configuration bundle between top-level control/datapath buffers
// and the tiled systolic-array sequencer.
interface tile_seq_controller_if #(
  parameter int TILE_CNT_W = 8
);
  logic                  start;
  logic [TILE_CNT_W-1:0] cfg_k_tiles;
  logic [TILE_CNT_W-1:0] cfg_n_tiles;
  logic                  cfg_accum;
  logic                  w_done;
  logic                  if_done;
  logic                  of_ready;
  logic                  w_read;
  logic                  if_read;
  logic                  clr_w;
  logic                  clr_if;
  logic                  switch;
  logic                  acc_clr;
  logic                  of_valid;
  logic                  ready;
  logic [TILE_CNT_W-1:0] k_idx;
  logic [TILE_CNT_W-1:0] n_idx;

  modport master (
    output start, cfg_k_tiles, cfg_n_tiles, cfg_accum, w_done, if_done, of_ready,
    input  w_read, if_read, clr_w, clr_if, switch, acc_clr, of_valid, ready, k_idx, n_idx
  );

  modport slave (
    input  start, cfg_k_tiles, cfg_n_tiles, cfg_accum, w_done, if_done, of_ready,
    output w_read, if_read, clr_w, clr_if, switch, acc_clr, of_valid, ready, k_idx, n_idx
  );
endinterface

// File: rtl/tile_seq_controller.sv
// Tiled matmul sequencer: walks N output tiles x K reduction tiles with
// double-buffered weight loads, drain timing, optional K accumulation and output handshake.
module tile_seq_controller #(
  parameter int SYS_ROWS   = 8,
  parameter int SYS_COLS   = 8,
  parameter int TILE_CNT_W = 8,
  parameter int DRAIN_LAT  = SYS_ROWS + SYS_COLS - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  tile_seq_controller_if.slave  bus
);

  localparam int DCNT_W = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;
  // DRAIN_LAT of 0 or 1 both collapse to a single drain cycle
  localparam logic [DCNT_W-1:0]     DRAIN_LAST = (DRAIN_LAT > 1) ? DCNT_W'(DRAIN_LAT - 1) : '0;
  localparam logic [TILE_CNT_W-1:0] ONE        = TILE_CNT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_INIT     = 4'd1,
    S_PRELOAD  = 4'd2,
    S_SWITCH_0 = 4'd3,
    S_STREAM   = 4'd4,
    S_DRAIN    = 4'd5,
    S_OUTPUT   = 4'd6,
    S_ADVANCE  = 4'd7,
    S_WAIT_W   = 4'd8,
    S_SWITCH   = 4'd9
  } state_t;

  state_t                state_r, state_s;
  logic [TILE_CNT_W-1:0] k_tiles_r, k_tiles_s, n_tiles_r, n_tiles_s;
  logic [TILE_CNT_W-1:0] k_idx_r, k_idx_s, n_idx_r, n_idx_s;
  logic                  accum_r, accum_s;
  logic                  w_next_rdy_r, w_next_rdy_s;
  logic [DCNT_W-1:0]     drain_cnt_r, drain_cnt_s;
  logic                  last_k_s, last_n_s, w_take_s, drain_end_s, has_next_s;

  logic w_read_r, if_read_r, clr_w_r, clr_if_r, switch_r, acc_clr_r, of_valid_r, ready_r;
  logic w_read_s, if_read_s, clr_w_s, clr_if_s, switch_s, acc_clr_s, of_valid_s, ready_s;

  // Next-state, index and flag logic
  always_comb begin
    state_s      = state_r;
    k_tiles_s    = k_tiles_r;
    n_tiles_s    = n_tiles_r;
    accum_s      = accum_r;
    k_idx_s      = k_idx_r;
    n_idx_s      = n_idx_r;
    w_next_rdy_s = w_next_rdy_r;
    drain_cnt_s  = drain_cnt_r;
    last_k_s     = (k_idx_r == (k_tiles_r - ONE));
    last_n_s     = (n_idx_r == (n_tiles_r - ONE));
    // a w_done only counts while the weight buffer is actually being read
    w_take_s     = bus.w_done & w_read_r;
    drain_end_s  = (drain_cnt_r == DRAIN_LAST);
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_s      = S_INIT;
          k_tiles_s    = (bus.cfg_k_tiles == '0) ? ONE : bus.cfg_k_tiles;
          n_tiles_s    = (bus.cfg_n_tiles == '0) ? ONE : bus.cfg_n_tiles;
          accum_s      = bus.cfg_accum;
          k_idx_s      = '0;
          n_idx_s      = '0;
          w_next_rdy_s = 1'b0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_INIT:     state_s = S_PRELOAD;
      S_PRELOAD:  state_s = bus.w_done ? S_SWITCH_0 : S_PRELOAD;
      S_SWITCH_0: state_s = S_STREAM;
      S_STREAM: begin
        w_next_rdy_s = w_next_rdy_r | w_take_s;
        if (bus.if_done) begin
          state_s     = S_DRAIN;
          drain_cnt_s = '0;
        end else begin
          state_s = S_STREAM;
        end
      end
      S_DRAIN: begin
        w_next_rdy_s = w_next_rdy_r | w_take_s;
        if (drain_end_s) begin
          state_s = (!accum_r || last_k_s) ? S_OUTPUT : S_ADVANCE;
        end else begin
          drain_cnt_s = drain_cnt_r + DCNT_W'(1);
        end
      end
      S_OUTPUT:   state_s = bus.of_ready ? S_ADVANCE : S_OUTPUT;
      S_ADVANCE: begin
        if (last_k_s && last_n_s) begin
          state_s = S_IDLE;
        end else if (w_next_rdy_r) begin
          state_s = S_SWITCH;
        end else begin
          state_s = S_WAIT_W;
        end
      end
      S_WAIT_W:   state_s = bus.w_done ? S_SWITCH : S_WAIT_W;
      S_SWITCH: begin
        state_s      = S_STREAM;
        w_next_rdy_s = 1'b0;
        if (last_k_s) begin
          k_idx_s = '0;
          n_idx_s = n_idx_r + ONE;
        end else begin
          k_idx_s = k_idx_r + ONE;
        end
      end
      default:    state_s = S_IDLE;
    endcase
  end

  // Moore output decode of the upcoming state so the outputs leave a flop
  always_comb begin
    w_read_s   = 1'b0;
    if_read_s  = 1'b0;
    clr_w_s    = 1'b0;
    clr_if_s   = 1'b0;
    switch_s   = 1'b0;
    acc_clr_s  = 1'b0;
    of_valid_s = 1'b0;
    ready_s    = 1'b0;
    has_next_s = !((k_idx_s == (k_tiles_s - ONE)) && (n_idx_s == (n_tiles_s - ONE)));
    case (state_s)
      S_IDLE:     ready_s = 1'b1;
      S_INIT: begin
        clr_w_s   = 1'b1;
        clr_if_s  = 1'b1;
        acc_clr_s = 1'b1;
      end
      S_PRELOAD:  w_read_s = 1'b1;
      S_SWITCH_0: begin
        switch_s = 1'b1;
        clr_w_s  = 1'b1;
        clr_if_s = 1'b1;
      end
      S_STREAM: begin
        if_read_s = 1'b1;
        w_read_s  = has_next_s & ~w_next_rdy_s;
      end
      S_DRAIN:    w_read_s = has_next_s & ~w_next_rdy_s;
      S_OUTPUT:   of_valid_s = 1'b1;
      S_ADVANCE:  ready_s = 1'b0;
      S_WAIT_W:   w_read_s = 1'b1;
      S_SWITCH: begin
        switch_s  = 1'b1;
        clr_w_s   = 1'b1;
        clr_if_s  = 1'b1;
        // indices still hold the finishing tile here; wrap of k means a fresh n tile
        acc_clr_s = (k_idx_s == (k_tiles_s - ONE)) | ~accum_s;
      end
      default:    ready_s = 1'b0;
    endcase
  end

  // State, configuration, index and flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      k_tiles_r    <= '0;
      n_tiles_r    <= '0;
      accum_r      <= 1'b0;
      k_idx_r      <= '0;
      n_idx_r      <= '0;
      w_next_rdy_r <= 1'b0;
      drain_cnt_r  <= '0;
    end else begin
      state_r      <= state_s;
      k_tiles_r    <= k_tiles_s;
      n_tiles_r    <= n_tiles_s;
      accum_r      <= accum_s;
      k_idx_r      <= k_idx_s;
      n_idx_r      <= n_idx_s;
      w_next_rdy_r <= w_next_rdy_s;
      drain_cnt_r  <= drain_cnt_s;
    end
  end

  // Registered control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_read_r   <= 1'b0;
      if_read_r  <= 1'b0;
      clr_w_r    <= 1'b0;
      clr_if_r   <= 1'b0;
      switch_r   <= 1'b0;
      acc_clr_r  <= 1'b0;
      of_valid_r <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      w_read_r   <= w_read_s;
      if_read_r  <= if_read_s;
      clr_w_r    <= clr_w_s;
      clr_if_r   <= clr_if_s;
      switch_r   <= switch_s;
      acc_clr_r  <= acc_clr_s;
      of_valid_r <= of_valid_s;
      ready_r    <= ready_s;
    end
  end

  assign bus.w_read   = w_read_r;
  assign bus.if_read  = if_read_r;
  assign bus.clr_w    = clr_w_r;
  assign bus.clr_if   = clr_if_r;
  assign bus.switch   = switch_r;
  assign bus.acc_clr  = acc_clr_r;
  assign bus.of_valid = of_valid_r;
  assign bus.ready    = ready_r;
  assign bus.k_idx    = k_idx_r;
  assign bus.n_idx    = n_idx_r;

endmodule

// File: tb/tb_tile_seq_controller.sv
// Bench for tile_seq_controller: responders emulate the buffers and sink, a monitor
// logs tile/output events, and a tile-order model predicts each job's event trace.
module tb_tile_seq_controller;
  localparam int TW = 8;
  localparam int DL = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tile_seq_controller_if #(.TILE_CNT_W(TW)) ifc ();

  tile_seq_controller #(.SYS_ROWS(8), .SYS_COLS(8), .TILE_CNT_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks = 0;
  int errors = 0;
  int w_lat = 8, if_lat = 16, or_mode = 1;
  int wcnt = 0, icnt = 0;
  int sw_cnt = 0, acc_cnt = 0;
  bit acc_pend = 1'b0, prev_if = 1'b0;
  int tk_q[$], tn_q[$], ta_q[$], ok_q[$], on_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_sig(input int code);
    case (code)
      0: return ifc.ready;
      1: return ifc.of_valid;
      2: return ifc.if_done;
      3: return ifc.if_read;
      4: return ifc.w_done;
      default: return ifc.w_read;
    endcase
  endfunction

  task automatic wait_sig(input int code, input logic val, input int bound, input string tag);
    int n = 0;
    while (get_sig(code) !== val && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, get_sig(code), val);
  endtask

  // Weight buffer: w_done after w_lat cycles of w_read (counted across gaps)
  initial begin
    ifc.w_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      ifc.w_done = 1'b0;
      if (ifc.ready) wcnt = 0;
      else if (ifc.w_read) begin
        wcnt++;
        if (wcnt >= w_lat) begin
          ifc.w_done = 1'b1;
          wcnt = 0;
        end
      end
    end
  end

  // Ifmap buffer: if_done in the if_lat-th consecutive if_read cycle
  initial begin
    ifc.if_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      ifc.if_done = 1'b0;
      if (!ifc.if_read) icnt = 0;
      else begin
        icnt++;
        if (icnt >= if_lat) begin
          ifc.if_done = 1'b1;
          icnt = 0;
        end
      end
    end
  end

  // Result sink
  initial begin
    ifc.of_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0: ifc.of_ready = ($urandom_range(0, 2) != 0);
        1: ifc.of_ready = 1'b1;
        default: ifc.of_ready = 1'b0;
      endcase
    end
  end

  // Event monitor
  initial begin
    forever begin
      @(negedge clk);
      if (ifc.switch) sw_cnt++;
      if (ifc.acc_clr) begin
        acc_cnt++;
        acc_pend = 1'b1;
      end
      if (ifc.if_read && !prev_if) begin
        tk_q.push_back(int'(ifc.k_idx));
        tn_q.push_back(int'(ifc.n_idx));
        ta_q.push_back(acc_pend ? 1 : 0);
        acc_pend = 1'b0;
      end
      if (ifc.of_valid && ifc.of_ready) begin
        ok_q.push_back(int'(ifc.k_idx));
        on_q.push_back(int'(ifc.n_idx));
      end
      prev_if = ifc.if_read;
    end
  end

  task automatic start_job(input int k, input int n, input bit acc);
    @(negedge clk); #1;
    tk_q.delete(); tn_q.delete(); ta_q.delete(); ok_q.delete(); on_q.delete();
    sw_cnt = 0; acc_cnt = 0; acc_pend = 1'b0;
    ifc.cfg_k_tiles = TW'(k);
    ifc.cfg_n_tiles = TW'(n);
    ifc.cfg_accum   = acc;
    ifc.start       = 1'b1;
    @(negedge clk);
    chk("init_pulses", {ifc.ready, ifc.clr_w, ifc.clr_if, ifc.acc_clr, ifc.switch}, 5'b01110);
    #1 ifc.start = 1'b0;
  endtask

  // Reference: k-inner/n-outer tile walk, one output per tile or per n when accumulating
  task automatic check_job(input int kk, input int nn, input bit acc);
    int t = 0, o = 0, exp_acc = 0, exp_out = 0;
    for (int n = 0; n < nn; n++) begin
      for (int k = 0; k < kk; k++) begin
        int a = (t == 0 || k == 0 || !acc) ? 1 : 0;
        exp_acc += a;
        if (t < tk_q.size())
          chk($sformatf("tile%0d", t), (tk_q[t] << 16) | (tn_q[t] << 8) | ta_q[t],
              (k << 16) | (n << 8) | a);
        t++;
        if (!acc || k == kk - 1) begin
          if (o < ok_q.size()) chk($sformatf("out%0d", o), (ok_q[o] << 8) | on_q[o], (k << 8) | n);
          o++;
        end
      end
    end
    exp_out = o;
    chk("tile_count", tk_q.size(), kk * nn);
    chk("out_count", ok_q.size(), exp_out);
    chk("switch_count", sw_cnt, kk * nn);
    chk("acc_clr_count", acc_cnt, exp_acc);
  endtask

  initial begin
    int n;
    logic [TW-1:0] k0, n0;
    rst = 1'b0;
    ifc.start = 1'b0;
    ifc.cfg_k_tiles = '0;
    ifc.cfg_n_tiles = '0;
    ifc.cfg_accum = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {ifc.ready, ifc.w_read, ifc.if_read, ifc.clr_w, ifc.clr_if,
        ifc.switch, ifc.acc_clr, ifc.of_valid, ifc.k_idx, ifc.n_idx}, {8'b1000_0000, 16'h0});
    #1 rst = 1'b1;

    // 1x1 job: preload latency, drain latency, return to ready
    w_lat = 8; if_lat = 16; or_mode = 1;
    start_job(1, 1, 1'b0);
    @(negedge clk);
    chk("preload_w_read", ifc.w_read, 1'b1);
    wait_sig(2, 1'b1, 200, "if_done_seen");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifc.of_valid && n < 40);
    chk("of_valid_latency", n, DL + 1);
    @(negedge clk);
    chk("ready_after_1", ifc.ready, 1'b0);
    @(negedge clk);
    chk("ready_after_2", ifc.ready, 1'b1);
    check_job(1, 1, 1'b0);

    // 3x2 accumulate job with prompt buffers
    w_lat = 2; if_lat = 4; or_mode = 0;
    start_job(3, 2, 1'b1);
    wait_sig(0, 1'b1, 3000, "job_3x2_done");
    check_job(3, 2, 1'b1);

    // 2x1: shadow weights late, forcing WAIT_W
    w_lat = 60; if_lat = 16; or_mode = 1;
    start_job(2, 1, 1'b1);
    wait_sig(3, 1'b1, 500, "stream0_start");
    wait_sig(3, 1'b0, 500, "drain0_start");
    repeat (14) @(negedge clk);
    chk("drain_last_w_read", ifc.w_read, 1'b1);
    @(negedge clk);
    chk("advance_idle", {ifc.w_read, ifc.of_valid, ifc.switch}, 3'b000);
    @(negedge clk);
    chk("wait_w_read", {ifc.w_read, ifc.if_read}, 2'b10);
    wait_sig(4, 1'b1, 200, "shadow_w_done");
    @(negedge clk);
    chk("switch_after_w_done", {ifc.switch, ifc.w_read, ifc.acc_clr}, 3'b100);
    wait_sig(0, 1'b1, 1000, "job_2x1_done");
    check_job(2, 1, 1'b1);

    // 1x2: sink back-pressure holds the output
    w_lat = 3; if_lat = 5; or_mode = 2;
    start_job(1, 2, 1'b0);
    wait_sig(1, 1'b1, 500, "first_of_valid");
    k0 = ifc.k_idx;
    n0 = ifc.n_idx;
    chk("hold_tile_n", n0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("output_hold", {ifc.of_valid, ifc.switch, ifc.k_idx, ifc.n_idx}, {1'b1, 1'b0, k0, n0});
    end
    or_mode = 1;
    wait_sig(0, 1'b1, 1000, "job_1x2_done");
    check_job(1, 2, 1'b0);

    // zero config acts as 1x1; start during STREAM is ignored
    w_lat = 4; if_lat = 20; or_mode = 0;
    start_job(0, 0, 1'b0);
    wait_sig(3, 1'b1, 500, "zero_cfg_stream");
    repeat (3) @(negedge clk);
    #1;
    ifc.cfg_k_tiles = TW'(5);
    ifc.cfg_n_tiles = TW'(5);
    ifc.start = 1'b1;
    @(negedge clk);
    #1 ifc.start = 1'b0;
    @(negedge clk);
    chk("start_ignored", {ifc.ready, ifc.if_read, ifc.k_idx, ifc.n_idx}, {2'b01, 16'h0});
    wait_sig(0, 1'b1, 1000, "job_zero_done");
    check_job(1, 1, 1'b0);

    // async reset in mid-STREAM, then a full job
    w_lat = 3; if_lat = 6; or_mode = 1;
    start_job(3, 3, 1'b0);
    wait_sig(3, 1'b1, 500, "rst_stream0");
    wait_sig(3, 1'b0, 500, "rst_drain0");
    wait_sig(3, 1'b1, 500, "rst_stream1");
    #1 rst = 1'b0;
    #1;
    chk("async_reset", {ifc.ready, ifc.w_read, ifc.if_read, ifc.clr_w, ifc.clr_if,
        ifc.switch, ifc.acc_clr, ifc.of_valid, ifc.k_idx, ifc.n_idx}, {8'b1000_0000, 16'h0});
    @(negedge clk);
    #1 rst = 1'b1;
    or_mode = 0;
    start_job(3, 3, 1'b1);
    wait_sig(0, 1'b1, 5000, "job_after_reset_done");
    check_job(3, 3, 1'b1);

    // randomized jobs
    for (int j = 0; j < 4; j++) begin
      int rk, rn;
      bit ra;
      rk = $urandom_range(1, 4);
      rn = $urandom_range(1, 3);
      ra = 1'($urandom_range(0, 1));
      w_lat = $urandom_range(1, 25);
      if_lat = $urandom_range(1, 12);
      or_mode = 0;
      start_job(rk, rn, ra);
      wait_sig(0, 1'b1, 8000, "rand_job_done");
      check_job(rk, rn, ra);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
